// File: rtl/countnox_pkg.sv
// rtl/countnox_pkg.sv - shared types and constants for the CountNoX engine and its sweeper
package countnox_pkg;
  localparam int CNX_XW    = 8;
  localparam int CNX_FW    = 8;
  localparam int CNX_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WRITE,
    GAP,
    FINISH
  } sweep_state_t;
endpackage

// File: rtl/countnox_sweeper_if.sv
// rtl/countnox_sweeper_if.sv - CountNoX go/done request channel plus histogram write port
interface countnox_sweeper_if
  import countnox_pkg::*;
#(
  parameter int XW = CNX_XW,
  parameter int FW = CNX_FW
);
  logic [XW-1:0] cnt_x;
  logic          cnt_go;
  logic          cnt_done;
  logic [FW-1:0] cnt_freq;
  logic          hist_we;
  logic [XW-1:0] hist_addr;
  logic [FW-1:0] hist_data;

  modport master (
    output cnt_x, cnt_go, hist_we, hist_addr, hist_data,
    input  cnt_done, cnt_freq
  );

  modport slave (
    input  cnt_x, cnt_go, hist_we, hist_addr, hist_data,
    output cnt_done, cnt_freq
  );
endinterface

// File: rtl/countnox_mode_tracker.sv
// rtl/countnox_mode_tracker.sv - running mode (lowest x wins ties) and frequency total
module countnox_mode_tracker
  import countnox_pkg::*;
#(
  parameter int XW = CNX_XW,
  parameter int FW = CNX_FW,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          update,
  input  logic [XW-1:0] x,
  input  logic [FW-1:0] freq,
  output logic [XW-1:0] mode_x,
  output logic [FW-1:0] mode_freq,
  output logic [TW-1:0] total
);
  logic          r_valid;
  logic [XW-1:0] r_mode_x;
  logic [FW-1:0] r_mode_freq;
  logic [TW-1:0] r_total;

  // r_valid marks that a first sample exists, so even an all-zero sweep reports X_FIRST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_mode_x    <= '0;
      r_mode_freq <= '0;
      r_total     <= '0;
    end else if (clear) begin
      r_valid     <= 1'b0;
      r_mode_x    <= '0;
      r_mode_freq <= '0;
      r_total     <= '0;
    end else if (update) begin
      r_valid <= 1'b1;
      r_total <= r_total + TW'(freq);
      if (!r_valid || (freq > r_mode_freq)) begin
        r_mode_x    <= x;
        r_mode_freq <= freq;
      end
    end
  end

  assign mode_x    = r_mode_x;
  assign mode_freq = r_mode_freq;
  assign total     = r_total;
endmodule

// File: rtl/countnox_sweeper.sv
// rtl/countnox_sweeper.sv - sweeps x through CountNoX one request at a time and builds a histogram
module countnox_sweeper
  import countnox_pkg::*;
#(
  parameter int XW      = CNX_XW,
  parameter int FW      = CNX_FW,
  parameter int TW      = 16,
  parameter int X_FIRST = 0,
  parameter int X_LAST  = 255,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [XW-1:0]      mode_x,
  output logic [FW-1:0]      mode_freq,
  output logic [TW-1:0]      total,
  countnox_sweeper_if.master cnx
);
  localparam int            WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [XW-1:0] X_FIRST_V = XW'(X_FIRST);
  localparam logic [XW-1:0] X_LAST_V  = XW'(X_LAST);

  sweep_state_t  r_state;
  logic [WDW-1:0] r_wdog;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [XW-1:0] r_cnt_x;
  logic          r_cnt_go;
  logic          r_hist_we;
  logic [XW-1:0] r_hist_addr;
  logic [FW-1:0] r_hist_data;

  logic w_clear;
  logic w_update;

  assign w_clear  = (r_state == IDLE) && start;
  assign w_update = (r_state == WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wdog      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cnt_x     <= '0;
      r_cnt_go    <= 1'b0;
      r_hist_we   <= 1'b0;
      r_hist_addr <= '0;
      r_hist_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= ISSUE;
            r_cnt_x  <= X_FIRST_V;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_cnt_go <= 1'b1;
            r_wdog   <= '0;
          end
        end
        ISSUE: begin
          r_wdog <= r_wdog + 1'b1;
          if (cnx.cnt_done) begin
            r_hist_data <= cnx.cnt_freq;
            r_hist_addr <= r_cnt_x;
            r_hist_we   <= 1'b1;
            r_cnt_go    <= 1'b0;
            r_state     <= WRITE;
          end else if (r_wdog == WD_LAST) begin
            r_error  <= 1'b1;
            r_cnt_go <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= FINISH;
          end
        end
        WRITE: begin
          r_hist_we <= 1'b0;
          r_state   <= GAP;
        end
        // Hold off the next go until the engine has dropped done after seeing go low
        GAP: begin
          if (!cnx.cnt_done) begin
            if (r_cnt_x == X_LAST_V) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_cnt_x  <= r_cnt_x + 1'b1;
              r_wdog   <= '0;
              r_cnt_go <= 1'b1;
              r_state  <= ISSUE;
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  countnox_mode_tracker #(
    .XW(XW),
    .FW(FW),
    .TW(TW)
  ) u_mode (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .update   (w_update),
    .x        (r_hist_addr),
    .freq     (r_hist_data),
    .mode_x   (mode_x),
    .mode_freq(mode_freq),
    .total    (total)
  );

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign cnx.cnt_x     = r_cnt_x;
  assign cnx.cnt_go    = r_cnt_go;
  assign cnx.hist_we   = r_hist_we;
  assign cnx.hist_addr = r_hist_addr;
  assign cnx.hist_data = r_hist_data;
endmodule

// File: tb/tb_countnox_sweeper.sv
// tb/tb_countnox_sweeper.sv - bench: CountNoX engine model, histogram scoreboard, three sweeper configs
module tb_countnox_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic       start_r [3];
  wire        busy_w  [3];
  wire        done_w  [3];
  wire        err_w   [3];
  wire  [7:0] modex_w [3];
  wire  [7:0] modef_w [3];
  wire  [15:0] total_w [3];

  countnox_sweeper_if if_a ();
  countnox_sweeper_if if_b ();
  countnox_sweeper_if if_c ();

  countnox_sweeper dut_a (
    .clk(clk), .reset(rst_n), .start(start_r[0]), .busy(busy_w[0]), .done(done_w[0]),
    .error(err_w[0]), .mode_x(modex_w[0]), .mode_freq(modef_w[0]), .total(total_w[0]), .cnx(if_a)
  );
  countnox_sweeper #(.TIMEOUT(64)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_r[1]), .busy(busy_w[1]), .done(done_w[1]),
    .error(err_w[1]), .mode_x(modex_w[1]), .mode_freq(modef_w[1]), .total(total_w[1]), .cnx(if_b)
  );
  countnox_sweeper #(.X_FIRST(10), .X_LAST(10)) dut_c (
    .clk(clk), .reset(rst_n), .start(start_r[2]), .busy(busy_w[2]), .done(done_w[2]),
    .error(err_w[2]), .mode_x(modex_w[2]), .mode_freq(modef_w[2]), .total(total_w[2]), .cnx(if_c)
  );

  wire       m_go   [3];
  wire [7:0] m_x    [3];
  wire       m_we   [3];
  wire [7:0] m_addr [3];
  wire [7:0] m_data [3];
  assign m_go[0] = if_a.cnt_go;     assign m_go[1] = if_b.cnt_go;     assign m_go[2] = if_c.cnt_go;
  assign m_x[0] = if_a.cnt_x;       assign m_x[1] = if_b.cnt_x;       assign m_x[2] = if_c.cnt_x;
  assign m_we[0] = if_a.hist_we;    assign m_we[1] = if_b.hist_we;    assign m_we[2] = if_c.hist_we;
  assign m_addr[0] = if_a.hist_addr; assign m_addr[1] = if_b.hist_addr; assign m_addr[2] = if_c.hist_addr;
  assign m_data[0] = if_a.hist_data; assign m_data[1] = if_b.hist_data; assign m_data[2] = if_c.hist_data;

  // Engine model: array contents in mem, done after lat[k] cycles of go, held until go drops
  logic [7:0] mem [256];
  int         lat [3];
  int         withhold [3];
  int         e_wait [3];
  logic       e_done [3];
  logic [7:0] e_freq [3];
  assign if_a.cnt_done = e_done[0]; assign if_a.cnt_freq = e_freq[0];
  assign if_b.cnt_done = e_done[1]; assign if_b.cnt_freq = e_freq[1];
  assign if_c.cnt_done = e_done[2]; assign if_c.cnt_freq = e_freq[2];

  function automatic logic [7:0] ref_count(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 256; i++) if (mem[i] == v) c++;
    return 8'(c);
  endfunction

  initial for (int k = 0; k < 3; k++) begin e_done[k] = 1'b0; e_freq[k] = 8'h00; e_wait[k] = 0; end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!m_go[k]) begin
        e_done[k] <= 1'b0;
        e_wait[k] <= 0;
      end else if (!e_done[k]) begin
        if ((e_wait[k] + 1 >= lat[k]) && (int'(m_x[k]) != withhold[k])) begin
          e_done[k] <= 1'b1;
          e_freq[k] <= ref_count(m_x[k]);
        end else begin
          e_wait[k] <= e_wait[k] + 1;
        end
      end
    end
  end

  // Scoreboard of histogram writes and protocol observations, sampled on the falling edge
  logic [7:0] hist [3][256];
  logic [7:0] h3 [256];
  int  we_cnt [3], req_cnt [3], done_cnt [3], proto_err [3];
  int  first_addr [3], last_addr [3], done_cyc [3], x5_rise [3];
  logic prev_go [3];
  logic [7:0] prev_x [3];

  initial for (int k = 0; k < 3; k++) begin
    we_cnt[k] = 0; req_cnt[k] = 0; done_cnt[k] = 0; proto_err[k] = 0;
    first_addr[k] = -1; last_addr[k] = -1; done_cyc[k] = 0; x5_rise[k] = 0;
    prev_go[k] = 1'b0; prev_x[k] = 8'h00;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_we[k]) begin
        hist[k][m_addr[k]] = m_data[k];
        if (we_cnt[k] == 0) first_addr[k] = int'(m_addr[k]);
        last_addr[k] = int'(m_addr[k]);
        we_cnt[k]++;
      end
      if (m_go[k] && !prev_go[k]) begin
        req_cnt[k]++;
        if (e_done[k]) proto_err[k]++;
        if (m_x[k] == 8'd5) x5_rise[k] = cyc;
      end
      if (m_go[k] && prev_go[k] && (m_x[k] != prev_x[k])) proto_err[k]++;
      if (done_w[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
      prev_go[k] = m_go[k];
      prev_x[k]  = m_x[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input int k, input string tag);
    check({tag, "_busy"}, 32'(busy_w[k]), 0);
    check({tag, "_done"}, 32'(done_w[k]), 0);
    check({tag, "_error"}, 32'(err_w[k]), 0);
    check({tag, "_cnt_go"}, 32'(m_go[k]), 0);
    check({tag, "_hist_we"}, 32'(m_we[k]), 0);
    check({tag, "_cnt_x"}, 32'(m_x[k]), 0);
    check({tag, "_hist_addr"}, 32'(m_addr[k]), 0);
    check({tag, "_hist_data"}, 32'(m_data[k]), 0);
    check({tag, "_mode_x"}, 32'(modex_w[k]), 0);
    check({tag, "_mode_freq"}, 32'(modef_w[k]), 0);
    check({tag, "_total"}, 32'(total_w[k]), 0);
  endtask

  task automatic start_sweep(input int k);
    we_cnt[k] = 0; req_cnt[k] = 0; done_cnt[k] = 0; first_addr[k] = -1; last_addr[k] = -1;
    for (int v = 0; v < 256; v++) hist[k][v] = 8'h00;
    @(posedge clk); #1 start_r[k] = 1'b1;
    @(posedge clk); #1 start_r[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, input string tag);
    int n = 0;
    while (done_cnt[k] == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt[k], 1);
    check({tag, "_busy_after"}, 32'(busy_w[k]), 0);
  endtask

  // Expected histogram and mode/total derived directly from the array contents
  task automatic compare_model(input int k, input int xf, input int xl, input string tag);
    logic [7:0]  ef;
    logic [7:0]  mf = 8'h00;
    int          mx = xf;
    logic [15:0] tot = 16'h0000;
    for (int v = xf; v <= xl; v++) begin
      ef = ref_count(8'(v));
      check($sformatf("%s_hist[%0d]", tag, v), 32'(hist[k][v]), 32'(ef));
      if (v == xf || ef > mf) begin
        mx = v;
        mf = ef;
      end
      tot = tot + 16'(ef);
    end
    check({tag, "_we_count"}, we_cnt[k], xl - xf + 1);
    check({tag, "_req_count"}, req_cnt[k], xl - xf + 1);
    check({tag, "_mode_x"}, 32'(modex_w[k]), mx);
    check({tag, "_mode_freq"}, 32'(modef_w[k]), 32'(mf));
    check({tag, "_total"}, 32'(total_w[k]), 32'(tot));
  endtask

  int we_before;
  int n_wait;

  initial begin
    for (int k = 0; k < 3; k++) begin start_r[k] = 1'b0; lat[k] = 3; withhold[k] = -1; end
    #1;
    for (int k = 0; k < 3; k++) check_all_zero(k, $sformatf("reset%0d", k));
    @(negedge clk); rst_n = 1'b1;

    // 1: a[i] = i mod 16, with a stray start pulse mid-sweep
    for (int i = 0; i < 256; i++) mem[i] = 8'(i % 16);
    start_sweep(0);
    repeat (50) @(posedge clk);
    #1 start_r[0] = 1'b1;
    @(posedge clk); #1 start_r[0] = 1'b0;
    wait_done(0, 5000, "t1");
    compare_model(0, 0, 255, "t1");
    check("t1_mode_x_const", 32'(modex_w[0]), 0);
    check("t1_mode_freq_const", 32'(modef_w[0]), 16);
    check("t1_total_const", 32'(total_w[0]), 256);
    check("t1_error", 32'(err_w[0]), 0);
    for (int v = 0; v < 256; v++) h3[v] = hist[0][v];

    // 2: a[i] = i except a[200..209] = 0x37
    for (int i = 0; i < 256; i++) mem[i] = (i >= 200 && i <= 209) ? 8'h37 : 8'(i);
    start_sweep(0);
    wait_done(0, 5000, "t2");
    compare_model(0, 0, 255, "t2");
    check("t2_hist37", 32'(hist[0][8'h37]), 11);
    check("t2_mode_x_const", 32'(modex_w[0]), 32'h37);
    check("t2_mode_freq_const", 32'(modef_w[0]), 11);

    // Randomized array contents and engine latency
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 63));
    lat[0] = int'($urandom_range(1, 7));
    start_sweep(0);
    wait_done(0, 8000, "rnd");
    compare_model(0, 0, 255, "rnd");

    // 3: engine never answers x = 5, TIMEOUT = 64
    for (int i = 0; i < 256; i++) mem[i] = 8'(i % 16);
    withhold[1] = 5;
    start_sweep(1);
    wait_done(1, 2000, "t3");
    check("t3_error", 32'(err_w[1]), 1);
    check("t3_we_count", we_cnt[1], 5);
    check("t3_last_addr", last_addr[1], 4);
    check("t3_cnt_go_low", 32'(m_go[1]), 0);
    check("t3_timeout_window", 32'((done_cyc[1] - x5_rise[1] >= 60) && (done_cyc[1] - x5_rise[1] <= 68)), 1);
    withhold[1] = -1;
    start_sweep(1);
    check("t3_error_cleared", 32'(err_w[1]), 0);
    wait_done(1, 5000, "t3b");
    check("t3b_error", 32'(err_w[1]), 0);
    compare_model(1, 0, 255, "t3b");

    // 6: single-value sweep X_FIRST = X_LAST = 10
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(8, 12));
    start_sweep(2);
    wait_done(2, 500, "t6");
    compare_model(2, 10, 10, "t6");
    check("t6_addr", last_addr[2], 10);

    // 4 and 5: 300-cycle engine latency, async reset while x = 0x40 is in flight
    for (int i = 0; i < 256; i++) mem[i] = 8'(i % 16);
    lat[0] = 300;
    start_sweep(0);
    n_wait = 0;
    while (!(m_go[0] && m_x[0] == 8'h40) && n_wait < 30000) begin
      @(posedge clk);
      n_wait++;
    end
    check("t4_reached_x40", 32'(n_wait < 30000), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_all_zero(0, "t4_async");
    we_before = we_cnt[0];
    check("t4_writes_before", we_before, 64);
    for (int v = 0; v < 64; v++) check($sformatf("t5_lat300_hist[%0d]", v), 32'(hist[0][v]), 32'(h3[v]));
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("t4_no_we_after", we_cnt[0], we_before);
    lat[0] = 3;
    start_sweep(0);
    wait_done(0, 5000, "t4r");
    check("t4r_first_addr", first_addr[0], 0);
    compare_model(0, 0, 255, "t4r");

    for (int k = 0; k < 3; k++) check($sformatf("proto%0d", k), proto_err[k], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/countnox_sweeper.md
Name: countnox_sweeper

Overview:
- Initiator for the CountNoX go/done protocol. Drives `x` and `go` into a CountNoX engine attached to the 256x8 array, and consumes `freq` and `done`.
- Sweeps `x` over a configurable range, one request per value, and writes each returned frequency into a histogram memory.
- Tracks the mode (most frequent value) and the total count.
- Sits beside the CountNoX top level and is the block that turns single queries into a full-array histogram.

Parameters:
- XW, 8, width of `x` / address of the histogram memory.
- FW, 8, width of `freq`.
- TW, 16, width of the `total` accumulator.
- X_FIRST, 0, first value queried.
- X_LAST, 255, last value queried; X_LAST >= X_FIRST.
- TIMEOUT, 4096, maximum cycles waiting for `cnt_done` per request.

Ports:
- clk, in, 1, system clock; all state on rising edge.
- reset, in, 1, asynchronous, active-low; 0 clears all state immediately.
- start, in, 1, begin sweep; sampled in IDLE only.
- busy, out, 1, high from the cycle after `start` is accepted until FINISH.
- done, out, 1, one-cycle pulse in FINISH.
- error, out, 1, set on timeout; held until next accepted `start`.
- cnt_x, out, XW, value presented to CountNoX `x`.
- cnt_go, out, 1, CountNoX `go`.
- cnt_done, in, 1, CountNoX `done`.
- cnt_freq, in, FW, CountNoX `freq`; valid while `cnt_done` = 1.
- hist_we, out, 1, histogram write strobe.
- hist_addr, out, XW, histogram write address.
- hist_data, out, FW, histogram write data.
- mode_x, out, XW, value with the highest frequency.
- mode_freq, out, FW, that frequency.
- total, out, TW, sum of all returned frequencies.

Behaviour:
- Reset (async, `reset` = 0): state=IDLE; `busy`, `done`, `error`, `cnt_go`, `hist_we` = 0; `cnt_x`, `hist_addr`, `hist_data`, `mode_x`, `mode_freq`, `total` = 0; watchdog = 0.
- Reset mid-sweep aborts at once. No further `hist_we` is issued. Histogram contents already written are not cleared.
- IDLE:
  - `start` = 1 -> ISSUE.
  - In the same transition: `cnt_x` = X_FIRST; `total`, `mode_x`, `mode_freq`, `error` cleared; `busy` = 1.
- ISSUE:
  - `cnt_go` = 1; `cnt_x` held stable; watchdog increments each cycle.
  - `cnt_done` = 1 sampled -> capture `cnt_freq` into `hist_data`, `hist_addr` = `cnt_x` -> WRITE.
  - Watchdog reaches TIMEOUT with no `cnt_done` -> `error` = 1, `cnt_go` = 0 -> FINISH.
- WRITE (exactly 1 cycle):
  - `hist_we` = 1; `cnt_go` = 0.
  - `total` += `hist_data`, zero-extended to TW; wraps modulo 2^TW.
  - If `hist_data` > `mode_freq` (strict), `mode_x`/`mode_freq` update. Ties keep the earlier (lower) x.
  - On the first request (`cnt_x` = X_FIRST), `mode` is loaded unconditionally.
  - -> GAP.
- GAP:
  - `cnt_go` = 0; wait until `cnt_done` = 0, so the engine has seen `go` low and returned to idle.
  - Then, if `cnt_x` = X_LAST -> FINISH; else `cnt_x` += 1, watchdog cleared -> ISSUE.
  - `cnt_go` is low for at least 1 cycle between consecutive requests.
- FINISH: `done` = 1 for 1 cycle; `busy` = 0 -> IDLE. Results held until the next accepted `start`.
- `start` while busy is ignored; no restart or queueing.
- Per request, minimum cost is engine latency + 2 cycles.
- No counting saturation in this block; `cnt_freq` is taken as delivered.

Decomposition:
- Shared package `countnox_pkg`:
  - State enum: IDLE, ISSUE, WRITE, GAP, FINISH.
  - Default XW/FW constants.
  - Array depth constant 256, also used by the CountNoX top.
- One natural sub-module, `countnox_mode_tracker`: running max with lowest-index tie-break, plus the `total` accumulator. Inputs: clear, update, x, freq.
- FSM and watchdog stay in the top.

Test Plan:
1. Bench CountNoX model over array a[i] = i mod 16; `start` pulse -> 256 `hist_we` strobes; hist[0..15] = 16, hist[16..255] = 0; `mode_x` = 0, `mode_freq` = 16, `total` = 256; `done` pulses once; `busy` low after.
2. a[i] = i except a[200..209] = 0x37 -> hist[0x37] = 11, hist[200..209] = 0; `mode_x` = 0x37, `mode_freq` = 11, `total` = 256.
3. Model withholds `done` for x = 5, TIMEOUT = 64 -> `hist_we` only for x = 0..4; `error` = 1; `done` pulse about 64 cycles after ISSUE(5); `cnt_go` = 0.
4. Assert `reset` = 0 while `cnt_x` = 0x40 and `cnt_go` = 1 -> all outputs 0 asynchronously; no `hist_we` after release; a new `start` restarts from x = 0.
5. Protocol checks throughout: `cnt_x` stable while `cnt_go` = 1; `cnt_go` low for ≥1 cycle and `cnt_done` low before each new request; `start` pulses during busy are ignored (no restart); model with 3-cycle and with 300-cycle latency gives identical histograms.
6. X_FIRST = 10, X_LAST = 10 -> exactly one request and one `hist_we` at addr 10; `done` pulse follows.
